// File: rtl/alu_mul_sequencer.sv
// Shift-add multiply sequencer that borrows the shared ALU for ADDU steps.
// When it is not running, the pipeline's ALU operands and control pass straight through.
module alu_mul_sequencer #(
   parameter int         MAX_ITER  = 32,
   parameter logic [3:0] ADDU_CODE = 4'd4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] mcand_i,
   input  logic [31:0] mplier_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] product_o,
   output logic        stall_o,
   input  logic [31:0] pipe_src1_i,
   input  logic [31:0] pipe_src2_i,
   input  logic [3:0]  pipe_ctrl_i,
   output logic [31:0] alu_src1_o,
   output logic [31:0] alu_src2_o,
   output logic [3:0]  alu_ctrl_o,
   input  logic [31:0] alu_result_i
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] acc, mc_r, mp_r, acc_nxt;
   logic [5:0]  cnt;
   logic        accept, zero_op, run_last;

   assign accept   = (state != RUN) && start_i;
   assign zero_op  = (mcand_i == 32'd0) || (mplier_i == 32'd0);
   assign acc_nxt  = mp_r[0] ? alu_result_i : acc;
   // Stop as soon as no multiplier bits remain above the one being consumed now.
   assign run_last = ((mp_r >> 1) == 32'd0) || (cnt == 6'(MAX_ITER - 1));

   always_comb begin
      state_nxt  = state;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      alu_src1_o = pipe_src1_i;
      alu_src2_o = pipe_src2_i;
      alu_ctrl_o = pipe_ctrl_i;
      case (state)
         IDLE, DONE: begin
            done_o = (state == DONE);
            if (start_i)
               state_nxt = zero_op ? DONE : RUN;
            else
               state_nxt = IDLE;
         end
         RUN: begin
            busy_o     = 1'b1;
            alu_src1_o = acc;
            alu_src2_o = mc_r;
            alu_ctrl_o = ADDU_CODE;
            if (run_last)
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stall_o = busy_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         acc       <= '0;
         mc_r      <= '0;
         mp_r      <= '0;
         cnt       <= '0;
         product_o <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            acc  <= '0;
            mc_r <= mcand_i;
            mp_r <= mplier_i;
            cnt  <= '0;
            if (zero_op)
               product_o <= '0;
         end else if (state == RUN) begin
            acc  <= acc_nxt;
            mc_r <= mc_r << 1;
            mp_r <= mp_r >> 1;
            cnt  <= cnt + 6'd1;
            // Latch the product including this cycle's add, on the way into DONE.
            if (run_last)
               product_o <= acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized self-checking bench for alu_mul_sequencer with a behavioural ALU
// and an arithmetic reference for the running accumulator and final product.
module tb_alu_mul_sequencer;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] mcand = '0, mplier = '0, pipe_src1 = '0, pipe_src2 = '0;
   logic [3:0]  pipe_ctrl = '0;
   logic        busy, done, stall;
   logic [31:0] product, alu_src1, alu_src2, alu_result;
   logic [3:0]  alu_ctrl;

   int errs = 0, checks = 0;

   alu_mul_sequencer dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .mcand_i(mcand), .mplier_i(mplier),
      .busy_o(busy), .done_o(done), .product_o(product), .stall_o(stall),
      .pipe_src1_i(pipe_src1), .pipe_src2_i(pipe_src2), .pipe_ctrl_i(pipe_ctrl),
      .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
      .alu_result_i(alu_result)
   );

   // Shared ALU: ADDU adds, any other code does something visibly different.
   assign alu_result = (alu_ctrl == 4'd4) ? alu_src1 + alu_src2 : alu_src1 ^ alu_src2;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int run_len(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      if (a == 0 || b == 0) return 0;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      return n;
   endfunction

   task automatic drive_pipe();
      pipe_src1 = $urandom;
      pipe_src2 = $urandom;
      pipe_ctrl = 4'($urandom_range(5, 15));
   endtask

   task automatic check_mux(input string tag);
      chk({tag, "_src1"}, alu_src1, pipe_src1);
      chk({tag, "_src2"}, alu_src2, pipe_src2);
      chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(pipe_ctrl));
   endtask

   // Called between edges in IDLE or DONE; returns in the DONE cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
      int n;
      logic [31:0] mask;
      n = run_len(a, b);
      start = 1'b1; mcand = a; mplier = b;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      mcand = $urandom; mplier = $urandom;
      drive_pipe();
      #1;
      for (int k = 0; k < n; k++) begin
         mask = (k == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - k));
         chk("run_busy", 32'(busy), 32'd1);
         chk("run_stall", 32'(stall), 32'd1);
         chk("run_done", 32'(done), 32'd0);
         chk("run_ctrl", 32'(alu_ctrl), 32'd4);
         chk("run_src1", alu_src1, a * (b & mask));
         chk("run_src2", alu_src2, a << k);
         @(negedge clk);
         drive_pipe();
         #1;
      end
      chk("done", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      chk("product", product, a * b);
      check_mux("done_mux");
   endtask

   task automatic after_op(input logic [31:0] exp_prod);
      @(negedge clk);
      drive_pipe();
      #1;
      chk("pulse_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("held_product", product, exp_prod);
      check_mux("idle_mux");
   endtask

   initial begin
      logic [31:0] a, b;
      drive_pipe();
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_product", product, 32'd0);
      check_mux("rst_mux");
      rst = 1'b0;

      pipe_src1 = 32'hA; pipe_src2 = 32'h5; pipe_ctrl = 4'd5;
      #1;
      check_mux("idle_fixed");

      run_op(32'd3, 32'd5, 1'b0);                 after_op(32'd15);
      run_op(32'd7, 32'hFFFF_FFFF, 1'b0);         after_op(32'hFFFF_FFF9);
      run_op(32'h0001_0000, 32'h0001_0000, 1'b0); after_op(32'd0);
      run_op(32'd11, 32'd13, 1'b0);               after_op(32'd143);
      run_op(32'd0, 32'h1234, 1'b0);              after_op(32'd0);
      run_op(32'h55, 32'd0, 1'b0);                after_op(32'd0);

      // start held high: ignored in RUN, re-accepted in DONE without an IDLE gap
      run_op(32'd6, 32'd9, 1'b1);
      run_op(32'd6, 32'd9, 1'b0);
      after_op(32'd54);

      // reset during the third RUN cycle discards the product
      start = 1'b1; mcand = 32'hFFFF; mplier = 32'hFFFF;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_product", product, 32'd0);
      check_mux("mid_rst_mux");
      for (int i = 0; i < 3; i++) after_op(32'd0);
      run_op(32'hFFFF, 32'hFFFF, 1'b0);
      after_op(32'hFFFE_0001);

      for (int i = 0; i < 25; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (i % 8 == 7) a = 32'd0;
         run_op(a, b, 1'b0);
         after_op(a * b);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
